// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles
// and a saturating bubble counter. Ports: id_* in, ex_* out, hazard_stall.
module id_ex_stage_reg #(
   parameter int XLEN  = 64,
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic             id_branch,
   input  logic             id_memread,
   input  logic             id_memtoreg,
   input  logic             id_memwrite,
   input  logic             id_alusrc,
   input  logic             id_regwrite,
   input  logic [1:0]       id_aluop,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic [RA_W-1:0]  id_rd,
   input  logic [3:0]       id_funct,
   input  logic             ex_flush,
   output logic             ex_valid,
   output logic             ex_branch,
   output logic             ex_memread,
   output logic             ex_memtoreg,
   output logic             ex_memwrite,
   output logic             ex_alusrc,
   output logic             ex_regwrite,
   output logic [1:0]       ex_aluop,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [RA_W-1:0]  ex_rs1,
   output logic [RA_W-1:0]  ex_rs2,
   output logic [RA_W-1:0]  ex_rd,
   output logic [3:0]       ex_funct,
   output logic             hazard_stall,
   output logic [CNT_W-1:0] bubble_count
);

   logic uses_rs2;
   logic rd_hit;
   logic bubble;

   // R-type, stores and branches read rs2; immediates do not
   assign uses_rs2 = ~id_alusrc | id_memwrite;

   assign rd_hit = (ex_rd == id_rs1) |
                   (uses_rs2 & (ex_rd == id_rs2));

   assign hazard_stall = id_valid & ex_valid & ex_memread &
                         (ex_rd != '0) & rd_hit;

   assign bubble = ex_flush | hazard_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_branch   <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_aluop    <= 2'b00;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct    <= 4'h0;
      end else if (bubble) begin
         // data fields keep their old values; only control is killed
         ex_valid    <= 1'b0;
         ex_branch   <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memtoreg <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_alusrc   <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_aluop    <= 2'b00;
         ex_rd       <= '0;
      end else begin
         ex_valid    <= id_valid;
         ex_branch   <= id_branch;
         ex_memread  <= id_memread;
         // an undriven decoder output must not turn into a writeback mux select
         ex_memtoreg <= (id_memtoreg === 1'b1);
         ex_memwrite <= id_memwrite;
         ex_alusrc   <= id_alusrc;
         ex_regwrite <= id_regwrite;
         ex_aluop    <= id_aluop;
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_funct    <= id_funct;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_count <= '0;
      end else if (bubble && id_valid && (bubble_count != '1)) begin
         bubble_count <= bubble_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for id_ex_stage_reg.
// Counter width reduced to 4 so saturation is reachable.
module tb_id_ex_stage_reg;

   localparam int XLEN  = 64;
   localparam int RA_W  = 5;
   localparam int CNT_W = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            id_valid, id_branch, id_memread, id_memtoreg;
   logic            id_memwrite, id_alusrc, id_regwrite;
   logic [1:0]      id_aluop;
   logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
   logic [3:0]      id_funct;
   logic            ex_flush;
   logic            ex_valid, ex_branch, ex_memread, ex_memtoreg;
   logic            ex_memwrite, ex_alusrc, ex_regwrite;
   logic [1:0]      ex_aluop;
   logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [RA_W-1:0] ex_rs1, ex_rs2, ex_rd;
   logic [3:0]      ex_funct;
   logic            hazard_stall;
   logic [CNT_W-1:0] bubble_count;

   int tests = 0;
   int fails = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_branch(id_branch),
      .id_memread(id_memread), .id_memtoreg(id_memtoreg),
      .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
      .id_regwrite(id_regwrite), .id_aluop(id_aluop),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_funct(id_funct), .ex_flush(ex_flush),
      .ex_valid(ex_valid), .ex_branch(ex_branch),
      .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
      .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
      .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop),
      .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct(ex_funct), .hazard_stall(hazard_stall),
      .bubble_count(bubble_count)
   );

   task automatic drv(input logic v, br, mr, m2r, mw, as, rw,
                      input logic [1:0] op,
                      input logic [4:0] rs1, rs2, rd,
                      input logic [63:0] pc);
      id_valid    = v;
      id_branch   = br;
      id_memread  = mr;
      id_memtoreg = m2r;
      id_memwrite = mw;
      id_alusrc   = as;
      id_regwrite = rw;
      id_aluop    = op;
      id_rs1      = rs1;
      id_rs2      = rs2;
      id_rd       = rd;
      id_funct    = 4'h0;
      id_pc       = pc;
      id_rs1_data = pc ^ 64'h1111;
      id_rs2_data = pc ^ 64'h2222;
      id_imm      = pc + 64'd4;
   endtask

   task automatic add_i(input logic v, input logic [4:0] rd, rs1, rs2,
                        input logic [63:0] pc);
      drv(v, 0, 0, 0, 0, 0, 1, 2'b10, rs1, rs2, rd, pc);
   endtask

   task automatic ld_i(input logic [4:0] rd, rs1, input logic [63:0] pc);
      drv(1, 0, 1, 1, 0, 1, 1, 2'b00, rs1, 5'd0, rd, pc);
   endtask

   task automatic addi_i(input logic [4:0] rd, rs1, rs2f,
                         input logic [63:0] pc);
      drv(1, 0, 0, 0, 0, 1, 1, 2'b00, rs1, rs2f, rd, pc);
   endtask

   task automatic sd_i(input logic [4:0] rs1, rs2, input logic [63:0] pc);
      drv(1, 0, 0, 0, 1, 1, 0, 2'b00, rs1, rs2, 5'd0, pc);
   endtask

   task automatic beq_i(input logic [4:0] rs1, rs2, input logic [63:0] pc);
      drv(1, 1, 0, 0, 0, 0, 0, 2'b01, rs1, rs2, 5'd0, pc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ex_flush = 1'b0;
      add_i(1, 5'd0, 5'd0, 5'd0, 64'h0);
      #1;
      tests++;
      if ({ex_valid, ex_regwrite, ex_memread, ex_aluop} !== 5'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 0",
                  {ex_valid, ex_regwrite, ex_memread, ex_aluop});
      end
      tests++;
      if (ex_pc !== 64'h0 || bubble_count !== 4'd0) begin
         fails++;
         $display("FAIL reset_data: pc %0h cnt %0d want 0 0", ex_pc, bubble_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      add_i(1, 5'd3, 5'd1, 5'd2, 64'h100);
      tick();
      tests++;
      if ({ex_valid, ex_regwrite, ex_aluop} !== 4'b1110 ||
          ex_rd !== 5'd3 || ex_pc !== 64'h100) begin
         fails++;
         $display("FAIL first_add: v/rw/op %b rd %0d pc %0h want 1110 3 100",
                  {ex_valid, ex_regwrite, ex_aluop}, ex_rd, ex_pc);
      end
      @(negedge clk);
      ex_flush = 1'b1;
      tick();
      tests++;
      if (bubble_count !== 4'd1 || ex_valid !== 1'b0 || ex_pc !== 64'h100) begin
         fails++;
         $display("FAIL pre_reset_flush: cnt %0d v %b pc %0h want 1 0 100",
                  bubble_count, ex_valid, ex_pc);
      end
      @(negedge clk);
      ex_flush = 1'b0;
      ld_i(5'd5, 5'd1, 64'h104);
      tick();
      @(negedge clk);
      add_i(1, 5'd6, 5'd5, 5'd7, 64'h108);
      #1;
      tests++;
      if (hazard_stall !== 1'b1) begin
         fails++;
         $display("FAIL pre_reset_hazard: got %b want 1", hazard_stall);
      end
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({hazard_stall, ex_valid, ex_memread, ex_regwrite} !== 4'b0 ||
          ex_rd !== 5'd0 || ex_pc !== 64'h0 || bubble_count !== 4'd0) begin
         fails++;
         $display("FAIL async_reset: hz/v/mr/rw %b rd %0d pc %0h cnt %0d want 0",
                  {hazard_stall, ex_valid, ex_memread, ex_regwrite},
                  ex_rd, ex_pc, bubble_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
   endtask

   task automatic test_load_use();
      @(negedge clk);
      ld_i(5'd5, 5'd1, 64'h200);
      tick();
      tests++;
      if (ex_memread !== 1'b1 || ex_memtoreg !== 1'b1 || ex_rd !== 5'd5) begin
         fails++;
         $display("FAIL ld_in_ex: mr %b m2r %b rd %0d want 1 1 5",
                  ex_memread, ex_memtoreg, ex_rd);
      end
      @(negedge clk);
      add_i(1, 5'd6, 5'd5, 5'd7, 64'h204);
      #1;
      tests++;
      if (hazard_stall !== 1'b1) begin
         fails++;
         $display("FAIL lu_stall: got %b want 1", hazard_stall);
      end
      tick();
      exp_cnt++;
      tests++;
      if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_memread !== 1'b0 ||
          ex_regwrite !== 1'b0) begin
         fails++;
         $display("FAIL lu_bubble: v %b rd %0d mr %b rw %b want 0 0 0 0",
                  ex_valid, ex_rd, ex_memread, ex_regwrite);
      end
      tests++;
      if (hazard_stall !== 1'b0) begin
         fails++;
         $display("FAIL lu_stall_clear: got %b want 0", hazard_stall);
      end
      tick();
      tests++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rs1 !== 5'd5 ||
          ex_rs2 !== 5'd7 || ex_pc !== 64'h204) begin
         fails++;
         $display("FAIL lu_add_ex: v %b rd %0d rs1 %0d rs2 %0d pc %0h want 1 6 5 7 204",
                  ex_valid, ex_rd, ex_rs1, ex_rs2, ex_pc);
      end
      tests++;
      if (bubble_count !== 4'd1) begin
         fails++;
         $display("FAIL lu_count: got %0d want 1", bubble_count);
      end
   endtask

   task automatic test_no_false_hazard();
      @(negedge clk);
      ld_i(5'd0, 5'd1, 64'h300);
      tick();
      @(negedge clk);
      add_i(1, 5'd6, 5'd0, 5'd0, 64'h304);
      #1;
      tests++;
      if (hazard_stall !== 1'b0) begin
         fails++;
         $display("FAIL ld_x0: got %b want 0", hazard_stall);
      end
      tick();
      @(negedge clk);
      ld_i(5'd5, 5'd1, 64'h308);
      tick();
      @(negedge clk);
      addi_i(5'd6, 5'd7, 5'd5, 64'h30c);
      #1;
      tests++;
      if (hazard_stall !== 1'b0) begin
         fails++;
         $display("FAIL addi_rs2f: got %b want 0", hazard_stall);
      end
      tick();
      tests++;
      if (ex_valid !== 1'b1 || ex_alusrc !== 1'b1 || ex_rd !== 5'd6) begin
         fails++;
         $display("FAIL addi_ex: v %b as %b rd %0d want 1 1 6",
                  ex_valid, ex_alusrc, ex_rd);
      end
      @(negedge clk);
      ld_i(5'd5, 5'd1, 64'h310);
      tick();
      @(negedge clk);
      sd_i(5'd7, 5'd5, 64'h314);
      #1;
      tests++;
      if (hazard_stall !== 1'b1) begin
         fails++;
         $display("FAIL sd_rs2: got %b want 1", hazard_stall);
      end
      tick();
      exp_cnt++;
      tests++;
      if (ex_valid !== 1'b0 || bubble_count !== 4'(exp_cnt)) begin
         fails++;
         $display("FAIL sd_bubble: v %b cnt %0d want 0 %0d",
                  ex_valid, bubble_count, exp_cnt);
      end
      tick();
      tests++;
      if (ex_valid !== 1'b1 || ex_memwrite !== 1'b1 || ex_rs2 !== 5'd5) begin
         fails++;
         $display("FAIL sd_ex: v %b mw %b rs2 %0d want 1 1 5",
                  ex_valid, ex_memwrite, ex_rs2);
      end
   endtask

   task automatic test_flush_priority();
      @(negedge clk);
      ld_i(5'd5, 5'd1, 64'h400);
      tick();
      @(negedge clk);
      add_i(1, 5'd6, 5'd5, 5'd7, 64'h404);
      ex_flush = 1'b1;
      #1;
      tests++;
      if (hazard_stall !== 1'b1) begin
         fails++;
         $display("FAIL fl_hazard: got %b want 1", hazard_stall);
      end
      tick();
      exp_cnt++;
      tests++;
      if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || bubble_count !== 4'(exp_cnt)) begin
         fails++;
         $display("FAIL fl_both: v %b rd %0d cnt %0d want 0 0 %0d",
                  ex_valid, ex_rd, bubble_count, exp_cnt);
      end
      @(negedge clk);
      add_i(0, 5'd8, 5'd1, 5'd2, 64'h408);
      tick();
      tests++;
      if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 ||
          bubble_count !== 4'(exp_cnt)) begin
         fails++;
         $display("FAIL fl_invalid: v %b rw %b cnt %0d want 0 0 %0d",
                  ex_valid, ex_regwrite, bubble_count, exp_cnt);
      end
      @(negedge clk);
      ex_flush = 1'b0;
   endtask

   task automatic test_x_sanitise();
      beq_i(5'd1, 5'd2, 64'h500);
      id_memtoreg = 1'bx;
      tick();
      tests++;
      if ({ex_valid, ex_branch, ex_memtoreg, ex_aluop} !== 5'b11001) begin
         fails++;
         $display("FAIL beq_x: v/br/m2r/op %b want 11001",
                  {ex_valid, ex_branch, ex_memtoreg, ex_aluop});
      end
      @(negedge clk);
      add_i(0, 5'd9, 5'd1, 5'd2, 64'h504);
      tick();
      tests++;
      if ({ex_valid, ex_regwrite, ex_aluop} !== 4'b0110 || ex_rd !== 5'd9 ||
          bubble_count !== 4'(exp_cnt)) begin
         fails++;
         $display("FAIL invalid_pass: v/rw/op %b rd %0d cnt %0d want 0110 9 %0d",
                  {ex_valid, ex_regwrite, ex_aluop}, ex_rd, bubble_count, exp_cnt);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         add_i(1, 5'd1, 5'd2, 5'd3, 64'h600);
         ex_flush = 1'b1;
         tick();
         if (exp_cnt < 15) exp_cnt++;
         if (i == 0 || i == 15 || i == 19) begin
            tests++;
            if (bubble_count !== 4'(exp_cnt)) begin
               fails++;
               $display("FAIL sat_%0d: got %0d want %0d", i, bubble_count, exp_cnt);
            end
         end
      end
      @(negedge clk);
      ex_flush = 1'b0;
      tick();
      tests++;
      if (bubble_count !== 4'd15 || ex_valid !== 1'b1) begin
         fails++;
         $display("FAIL sat_hold: cnt %0d v %b want 15 1", bubble_count, ex_valid);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_false_hazard();
      test_flush_priority();
      test_x_sanitise();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
